systolic_ctrl: RTL

- Sequencer for an ARRAY_DIM x ARRAY_DIM grid of systolic_pe tiles, computing weight-stationary matrix-vector products.
- Accepts a full weight matrix and buffers it, then shifts it into the grid with ld_weight.
- Streams activation vectors into the row inputs with diagonal skew, de-skews the column sums from the bottom row, and emits one result vector per accepted activation vector.
- Sits between the host/DMA streams and the array edge ports.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_skew_line.sv | 33 +++
 rtl/systolic_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer and its delay lines.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WSHIFT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Cycles from an accepted activation beat to the matching r_valid.
    function automatic int calc_lat(input int array_dim, input int pe_latency);
        return (2 * array_dim - 1) * pe_latency + 1;
    endfunction

    // Low bit of lane 'lane' in a packed vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Fixed-depth DATA_SIZE-wide delay line, cleared on reset; DEPTH = 0 is a plain wire.
module systolic_skew_line #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_pipe
            logic [DATA_SIZE-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary sequencer for an ARRAY_DIM^2 systolic grid; results appear calc_lat() cycles after each accepted vector.
// r_valid has no backpressure (the array never stalls); SYSTOLIC_CTRL_PERF_EN adds perf_cycles/perf_bubbles counters.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int ARRAY_DIM  = 4,
    parameter int PE_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_W-1:0]               num_vecs,
    output logic                           busy,
    output logic                           done,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [DATA_SIZE*ARRAY_DIM-1:0] w_data,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [DATA_SIZE*ARRAY_DIM-1:0] a_data,
    output logic [ARRAY_DIM-1:0]           arr_enable,
    output logic [ARRAY_DIM-1:0]           arr_ld_weight,
    output logic [DATA_SIZE*ARRAY_DIM-1:0] arr_top_sum,
    output logic [DATA_SIZE*ARRAY_DIM-1:0] arr_left_data,
    input  logic [DATA_SIZE*ARRAY_DIM-1:0] arr_bottom_sum,
    output logic                           r_valid,
    output logic [DATA_SIZE*ARRAY_DIM-1:0] r_data
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_cycles,
    output logic [31:0]                    perf_bubbles
`endif
);

    localparam int VW       = DATA_SIZE * ARRAY_DIM;
    localparam int ROW_W    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int LAT      = calc_lat(ARRAY_DIM, PE_LATENCY);
    localparam int VP_DEPTH = LAT - 1;

    state_t               state;
    logic [CNT_W-1:0]     vec_target;
    logic [CNT_W-1:0]     beat_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic [VW-1:0]        wbuf [ARRAY_DIM];
    logic [VP_DEPTH-1:0]  vpipe;
    logic                 vpipe_empty;
    logic                 accept;
    logic [VW-1:0]        inj_data;
    logic [VW-1:0]        deskew;

    assign accept      = a_valid && a_ready;
    assign inj_data    = accept ? a_data : '0;
    assign vpipe_empty = (vpipe == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            vec_target    <= '0;
            beat_cnt      <= '0;
            row_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            w_ready       <= 1'b0;
            a_ready       <= 1'b0;
            arr_enable    <= '0;
            arr_ld_weight <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_target <= num_vecs;
                        beat_cnt   <= '0;
                        row_cnt    <= '0;
                        busy       <= 1'b1;
                        w_ready    <= 1'b1;
                        state      <= WLOAD;
                    end
                end
                WLOAD: begin
                    if (w_valid) begin
                        if (row_cnt == ROW_W'(ARRAY_DIM - 1)) begin
                            row_cnt       <= '0;
                            w_ready       <= 1'b0;
                            arr_enable    <= '1;
                            arr_ld_weight <= '1;
                            state         <= WSHIFT;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                WSHIFT: begin
                    if (row_cnt == ROW_W'(ARRAY_DIM - 1)) begin
                        row_cnt       <= '0;
                        arr_ld_weight <= '0;
                        if (vec_target == '0) begin
                            done       <= 1'b1;
                            arr_enable <= '0;
                            state      <= DONE;
                        end else begin
                            a_ready <= 1'b1;
                            state   <= STREAM;
                        end
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == vec_target - 1'b1) begin
                            a_ready <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (vpipe_empty) begin
                        done       <= 1'b1;
                        arr_enable <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Weight buffer holds data only; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (state == WLOAD && w_valid && w_ready) wbuf[row_cnt] <= w_data;
    end

    // Last row goes in first so that row r settles in PE row r after ARRAY_DIM shifts.
    always_comb begin
        arr_top_sum = '0;
        if (state == WSHIFT) arr_top_sum = wbuf[ROW_W'(ARRAY_DIM - 1) - row_cnt];
    end

    genvar g;
    generate
        for (g = 0; g < ARRAY_DIM; g++) begin : g_lane
            systolic_skew_line #(
                .DATA_SIZE (DATA_SIZE),
                .DEPTH     (g * PE_LATENCY)
            ) u_in_skew (
                .clk   (clk),
                .reset (reset),
                .din   (inj_data[lane_lo(g, DATA_SIZE) +: DATA_SIZE]),
                .dout  (arr_left_data[lane_lo(g, DATA_SIZE) +: DATA_SIZE])
            );

            systolic_skew_line #(
                .DATA_SIZE (DATA_SIZE),
                .DEPTH     ((ARRAY_DIM - 1 - g) * PE_LATENCY)
            ) u_out_deskew (
                .clk   (clk),
                .reset (reset),
                .din   (arr_bottom_sum[lane_lo(g, DATA_SIZE) +: DATA_SIZE]),
                .dout  (deskew[lane_lo(g, DATA_SIZE) +: DATA_SIZE])
            );
        end
    endgenerate

    // Valid tokens travel alongside the data, so the pipe empties exactly when the last result has been emitted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            vpipe   <= {vpipe[VP_DEPTH-2:0], accept};
            r_valid <= vpipe[VP_DEPTH-1];
            if (vpipe[VP_DEPTH-1]) r_data <= deskew;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_bubbles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles  <= '0;
            perf_bubbles <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 1'b1;
            if (state == STREAM && !accept) perf_bubbles <= perf_bubbles + 1'b1;
        end
    end
`endif

endmodule
